dac_spi_receiver: RTL
=====================

DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 Parameter FRAME_BITS, default 16, SHALL set the number of SCLK bits in a valid frame.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on each SPI input (minimum 2).
REQ-003 CLOCK_50  input  1  SHALL be the single 50 MHz clock; all logic runs on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 DAC_CSB  input  1  SHALL be the active-low SPI chip select from the DAC master.
REQ-006 DAC_SCLK  input  1  SHALL be the SPI serial clock; data is sampled on its rising edge.
REQ-007 DAC_DIN  input  1  SHALL be the SPI serial data, MSB first.
REQ-008 dac_ctrl  output  4  SHALL be frame bits [15:12] of the last valid frame.
REQ-009 dac_code  output  12  SHALL be frame bits [11:0] of the last valid frame.
REQ-010 frame_valid  output  1  SHALL be a one-cycle pulse marking a new dac_ctrl/dac_code pair.
REQ-011 busy  output  1  SHALL be high while a frame is in progress (state SHIFT).
REQ-012 frame_err  output  1  SHALL be a one-cycle pulse on a malformed frame (macro-dependent, see Configuration).
REQ-013 err_count  output  8  SHALL be a saturating count of frame_err pulses (macro-dependent).

Function
REQ-014 DAC_CSB, DAC_SCLK and DAC_DIN SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last synchronizer stage to one additional delay flop.
REQ-015 The master SHALL guarantee SCLK high and low times of at least 2 CLOCK_50 cycles (SCLK max 12.5 MHz); behaviour is undefined otherwise.
REQ-016 States SHALL be IDLE, SHIFT, RESYNC.
REQ-017 IDLE -> SHIFT on a synchronized CSB falling edge; bit counter and shift register cleared in that cycle.
REQ-018 In SHIFT, each synchronized SCLK rising edge SHALL shift synchronized DIN into the LSB and increment the bit counter, which saturates at FRAME_BITS+1.
REQ-019 SHIFT -> IDLE on a synchronized CSB rising edge; if the count equals FRAME_BITS, dac_ctrl/dac_code SHALL load the shift register and frame_valid SHALL pulse in the following cycle.
REQ-020 On CSB rising with count not equal to FRAME_BITS (short or long frame), outputs SHALL hold their previous values and frame_valid SHALL NOT pulse.
REQ-021 If an SCLK rising edge and a CSB rising edge are detected in the same cycle, the SCLK bit SHALL be counted before the frame-end decision.
REQ-022 SCLK edges in IDLE or RESYNC SHALL be ignored.
REQ-023 Latency from the DAC_CSB pin rising to frame_valid high SHALL be SYNC_STAGES+2 cycles (+1 for asynchronous sampling uncertainty).
REQ-024 Back-to-back frames with CSB high for at least 2 cycles SHALL each be received.

Reset
REQ-025 While rst is high: state = RESYNC, dac_ctrl = 0, dac_code = 0, frame_valid = 0, busy = 0, frame_err = 0, err_count = 0, all synchronizer flops = 1 (bus idle).
REQ-026 RESYNC -> IDLE only after synchronized CSB is seen high, so a frame already in progress when reset is released is discarded without error.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately; no frame_valid or frame_err is generated for it.

Configuration
REQ-028 With macro DAC_RX_FRAME_ERR_EN defined: frame_err pulses one cycle in the case of REQ-020, and err_count increments, saturating at 255.
REQ-029 Without DAC_RX_FRAME_ERR_EN: frame_err and err_count SHALL be tied to 0 and no error logic is synthesized; all other behaviour is identical.

Verification
REQ-030 Frame 0x3A5C at SCLK = 5 MHz -> one frame_valid pulse, dac_ctrl = 0x3, dac_code = 0xA5C, latency per REQ-023.
REQ-031 14-bit frame after a valid 0x1FFF frame -> no frame_valid, outputs stay 0x1/0xFFF; with macro, frame_err pulses and err_count = 1.
REQ-032 17-bit frame -> no frame_valid; with macro, err_count increments; without macro, err_count stays 0.
REQ-033 rst pulsed after bit 8 of a frame, CSB held low through remaining bits -> outputs 0, no pulses; next full frame 0xF000 received correctly.
REQ-034 Three back-to-back frames 0x0001, 0x8000, 0xFFFF with 2-cycle CSB gaps at 12.5 MHz SCLK -> three frame_valid pulses with matching values, in order.
REQ-035 With macro, 300 short frames -> err_count saturates at 255.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: receives DAC control frames from an SPI master (mode 0,
// MSB first) clocked entirely by CLOCK_50.  Each SPI pin is synchronized,
// and edges are found on the synchronized copies.  A frame counts as valid
// only when exactly FRAME_BITS SCLK rising edges occur while CSB is low.
//
// Optional feature macro: DAC_RX_FRAME_ERR_EN
//   defined   -> malformed frames pulse frame_err and bump err_count (saturating)
//   undefined -> frame_err / err_count tied low, no error logic built
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus idle, waiting for CSB falling edge
// SHIFT  | frame in progress, shifting DIN on SCLK rising edges
// RESYNC | after reset: wait for synchronizers to flush and CSB high

module dac_spi_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        DAC_CSB,
    input  logic        DAC_SCLK,
    input  logic        DAC_DIN,
    output logic [3:0]  dac_ctrl,
    output logic [11:0] dac_code,
    output logic        frame_valid,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int SR_W  = (FRAME_BITS < 16) ? 16 : FRAME_BITS;
    localparam int CW    = $clog2(FRAME_BITS + 2);
    localparam int FLUSH = SYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, din_sync;
    logic                   csb_dly, sclk_dly;
    logic                   csb_s, sclk_s, din_s;
    logic                   csb_fall, csb_rise, sclk_rise;

    logic [FW-1:0]   flush_cnt;
    logic            flush_done;
    logic [CW-1:0]   bit_cnt, cnt_next;
    logic [SR_W-1:0] shift_reg;
    logic            start, shift_en, frame_ok, ok_pend;

    // Synchronizers plus one delay flop on CSB/SCLK; reset to the idle-bus level
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            csb_sync  <= '1;
            sclk_sync <= '1;
            din_sync  <= '1;
            csb_dly   <= 1'b1;
            sclk_dly  <= 1'b1;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], DAC_CSB};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], DAC_SCLK};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], DAC_DIN};
            csb_dly   <= csb_s;
            sclk_dly  <= sclk_s;
        end
    end

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign csb_fall  = csb_dly & ~csb_s;
    assign csb_rise  = ~csb_dly & csb_s;
    assign sclk_rise = ~sclk_dly & sclk_s;

    // After reset the synchronizers still hold their forced-high value, so
    // RESYNC must not trust csb_s until the real pin level has flushed through;
    // otherwise a frame in progress would look like a fresh CSB falling edge.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            flush_cnt <= FW'(FLUSH);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
        end
    end

    assign flush_done = (flush_cnt == '0);

    // A coincident SCLK edge is folded into the count before the frame-end test
    assign cnt_next = (sclk_rise && bit_cnt != CNT_MAX) ? bit_cnt + CW'(1) : bit_cnt;

    // State register
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= RESYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        frame_ok = 1'b0;
        case (state_q)
            RESYNC: begin
                if (flush_done && csb_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (csb_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                shift_en = sclk_rise;
                if (csb_rise) begin
                    state_d  = IDLE;
                    frame_ok = (cnt_next == CNT_FULL);
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    assign busy = (state_q == SHIFT);

    // Shift register, bit counter and output capture one cycle after frame end
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            ok_pend     <= 1'b0;
            frame_valid <= 1'b0;
            dac_ctrl    <= '0;
            dac_code    <= '0;
        end else begin
            ok_pend     <= frame_ok;
            frame_valid <= ok_pend;
            if (ok_pend) begin
                {dac_ctrl, dac_code} <= shift_reg[15:0];
            end
            if (start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (shift_en) begin
                bit_cnt   <= cnt_next;
                shift_reg <= {shift_reg[SR_W-2:0], din_s};
            end
        end
    end

`ifdef DAC_RX_FRAME_ERR_EN
    logic frame_bad, bad_pend;

    assign frame_bad = (state_q == SHIFT) && csb_rise && (cnt_next != CNT_FULL);

    // Error pulse aligned with where frame_valid would have fired; saturating count
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            bad_pend  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            bad_pend  <= frame_bad;
            frame_err <= bad_pend;
            if (bad_pend && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign frame_err = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule
